pos_cell_ctrl: RTL and testbench

Sequencer and arbiter for one single-port position cell memory (2-cycle read latency, address 0 holds the particle count, words 1..N hold {posz,posy,posx}). It shares the memory between two requesters. The force-evaluation reader streams every particle of the cell. The motion-update writer refills the cell and then commits the new count. One instance sits beside each cell memory inside the position cache.

---
 rtl/pos_cell_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pos_cell_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pos_cell_ctrl.sv
// Arbiter and sequencer for one single-port position cell memory: streams a whole
// cell to the force reader, or refills it from the motion writer and commits the count.
module pos_cell_ctrl #(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req,
  output logic                  rd_gnt,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] rd_pid,
  output logic                  rd_last,
  output logic                  rd_done,
  input  logic                  wr_req,
  output logic                  wr_gnt,
  output logic                  wr_ready,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_end,
  output logic                  wr_done,
  output logic                  wr_ovf,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam logic [ADDR_WIDTH-1:0] MAX_N = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE, RD_CNT, RD_WAIT, RD_STREAM, RD_DRAIN, WR, WR_CNT
  } state_t;

  state_t                r_state;
  logic                  r_wait;
  logic                  r_last_rd;
  logic [ADDR_WIDTH-1:0] r_n;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  r_iss;
  logic                  r_v1;
  logic                  r_v2;
  logic [ADDR_WIDTH-1:0] r_pid1;
  logic [ADDR_WIDTH-1:0] r_pid2;

  logic [ADDR_WIDTH-1:0] w_q_cnt;
  logic [ADDR_WIDTH-1:0] w_n;
  logic [ADDR_WIDTH-1:0] w_cnt;
  logic                  w_last;

  assign w_q_cnt = mem_q[ADDR_WIDTH-1:0];
  assign w_n     = (w_q_cnt > MAX_N) ? MAX_N : w_q_cnt;
  // The pointer starts at 1, so the number of stored words is always one less.
  assign w_cnt   = r_ptr - ONE;
  assign w_last  = r_v2 && (r_pid2 == r_n);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_wait      <= 1'b0;
      r_last_rd   <= 1'b0;
      r_n         <= '0;
      r_ptr       <= '0;
      r_iss       <= 1'b0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_pid1      <= '0;
      r_pid2      <= '0;
      rd_gnt      <= 1'b0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      rd_pid      <= '0;
      rd_last     <= 1'b0;
      rd_done     <= 1'b0;
      wr_gnt      <= 1'b0;
      wr_ready    <= 1'b0;
      wr_done     <= 1'b0;
      wr_ovf      <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_rden    <= 1'b0;
      mem_wren    <= 1'b0;
    end else begin
      rd_gnt  <= 1'b0;
      wr_gnt  <= 1'b0;
      wr_done <= 1'b0;

      // Read return path: issue flag and pid ride alongside the 2-cycle memory latency.
      r_v1     <= r_iss;
      r_pid1   <= mem_address;
      r_v2     <= r_v1;
      r_pid2   <= r_pid1;
      rd_valid <= r_v2;
      rd_pid   <= r_pid2;
      rd_last  <= w_last;
      rd_done  <= w_last;
      if (r_v2) rd_data <= mem_q;

      case (r_state)
        IDLE: begin
          mem_rden <= 1'b0;
          mem_wren <= 1'b0;
          if (rd_req && (!wr_req || !r_last_rd)) begin
            rd_gnt      <= 1'b1;
            r_last_rd   <= 1'b1;
            mem_address <= '0;
            mem_rden    <= 1'b1;
            r_state     <= RD_CNT;
          end else if (wr_req) begin
            wr_gnt    <= 1'b1;
            r_last_rd <= 1'b0;
            wr_ready  <= 1'b1;
            wr_ovf    <= 1'b0;
            r_ptr     <= ONE;
            r_state   <= WR;
          end
        end
        RD_CNT: begin
          mem_rden <= 1'b0;
          r_wait   <= 1'b0;
          r_state  <= RD_WAIT;
        end
        RD_WAIT: begin
          r_wait <= 1'b1;
          if (r_wait) begin
            r_n <= w_n;
            if (w_n == '0) begin
              rd_done <= 1'b1;
              r_state <= IDLE;
            end else begin
              mem_address <= ONE;
              mem_rden    <= 1'b1;
              r_iss       <= 1'b1;
              r_state     <= RD_STREAM;
            end
          end
        end
        RD_STREAM: begin
          if (mem_address == r_n) begin
            mem_rden <= 1'b0;
            r_iss    <= 1'b0;
            r_wait   <= 1'b0;
            r_state  <= RD_DRAIN;
          end else begin
            mem_address <= mem_address + ONE;
          end
        end
        RD_DRAIN: begin
          r_wait <= 1'b1;
          if (r_wait) r_state <= IDLE;
        end
        WR: begin
          mem_wren <= 1'b0;
          if (wr_valid) begin
            if (r_ptr <= MAX_N) begin
              mem_wren    <= 1'b1;
              mem_address <= r_ptr;
              mem_data    <= wr_data;
              r_ptr       <= r_ptr + ONE;
            end else begin
              wr_ovf <= 1'b1;
            end
          end
          if (wr_end) begin
            wr_ready <= 1'b0;
            r_state  <= WR_CNT;
          end
        end
        WR_CNT: begin
          mem_wren    <= 1'b1;
          mem_address <= '0;
          mem_data    <= DATA_WIDTH'(w_cnt);
          wr_done     <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pos_cell_ctrl.sv
// Bench for pos_cell_ctrl: behavioural cell memory, a per-cycle read-stream scoreboard
// built from memory contents at grant time, and directed read/write/arbitration/reset cases.
module tb_pos_cell_ctrl;
  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_req = 1'b0, wr_req = 1'b0, wr_valid = 1'b0, wr_end = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_gnt, rd_valid, rd_last, rd_done;
  logic [DW-1:0] rd_data, mem_data;
  logic [AW-1:0] rd_pid, mem_address;
  logic          wr_gnt, wr_ready, wr_done, wr_ovf, mem_rden, mem_wren;
  logic [DW-1:0] mem_q, q1;

  logic [DW-1:0] mem [0:PN-1];
  logic          pl_en = 1'b0;
  int            pl_addr = 0;
  logic [DW-1:0] pl_data = '0;

  int n_checks = 0, n_err = 0, cyc = 0;
  bit last_ovf = 1'b0;

  pos_cell_ctrl #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_pid(rd_pid), .rd_last(rd_last), .rd_done(rd_done),
    .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_ready(wr_ready), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_end(wr_end), .wr_done(wr_done), .wr_ovf(wr_ovf),
    .mem_address(mem_address), .mem_data(mem_data), .mem_rden(mem_rden),
    .mem_wren(mem_wren), .mem_q(mem_q)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port memory with 2-cycle read latency; pl_* is a bench-only preload port.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_wren) mem[int'(mem_address)] <= mem_data;
    if (mem_rden) q1 <= mem[int'(mem_address)];
    mem_q <= q1;
  end

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] all_outs();
    return {38'd0, rd_gnt, rd_valid, rd_data, rd_pid, rd_last, rd_done, wr_gnt, wr_ready,
            wr_done, wr_ovf, mem_address, mem_data, mem_rden, mem_wren};
  endfunction

  // Read-stream scoreboard keyed by cycle number
  bit            exp_v    [int];
  logic [AW-1:0] exp_pid  [int];
  logic [DW-1:0] exp_d    [int];
  bit            exp_last [int];
  bit            exp_done [int];

  always @(negedge clk) begin : cmp
    int n;
    bit ev;
    if (!rst) begin
      check("reset_outputs", all_outs(), '0);
      exp_v.delete(); exp_pid.delete(); exp_d.delete(); exp_last.delete(); exp_done.delete();
    end else begin
      check("rden_wren_excl", mem_rden & mem_wren, 1'b0);
      check("gnt_excl", rd_gnt & wr_gnt, 1'b0);
      ev = exp_v.exists(cyc);
      check("rd_valid", rd_valid, ev);
      if (ev) begin
        check("rd_pid", rd_pid, exp_pid[cyc]);
        check("rd_data", rd_data, exp_d[cyc]);
        check("rd_last", rd_last, exp_last[cyc]);
      end else begin
        check("rd_last_idle", rd_last, 1'b0);
      end
      check("rd_done", rd_done, exp_done.exists(cyc));
      if (rd_gnt) begin
        // Words k=1..N come back 5+k cycles after the grant; an empty cell finishes after 3.
        n = int'(mem[0][AW-1:0]);
        if (n > PN - 1) n = PN - 1;
        if (n == 0) exp_done[cyc + 3] = 1'b1;
        for (int k = 1; k <= n; k++) begin
          exp_v[cyc + 5 + k]    = 1'b1;
          exp_pid[cyc + 5 + k]  = AW'(k);
          exp_d[cyc + 5 + k]    = mem[k];
          exp_last[cyc + 5 + k] = (k == n);
          if (k == n) exp_done[cyc + 5 + k] = 1'b1;
        end
      end
    end
  end

  task automatic poke(input int a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  logic [AW-1:0] addr_q[$];
  logic [AW-1:0] pid_q[$];
  logic [DW-1:0] data_q[$];
  int g_cyc, done_cyc, first_v;

  task automatic do_read(input int max_cyc);
    addr_q.delete(); pid_q.delete(); data_q.delete();
    g_cyc = -1; done_cyc = -1; first_v = -1;
    rd_req = 1'b1;
    for (int i = 0; i < max_cyc && done_cyc < 0; i++) begin
      @(negedge clk);
      if (rd_gnt && g_cyc < 0) begin g_cyc = cyc; rd_req = 1'b0; end
      if (mem_rden) addr_q.push_back(mem_address);
      if (rd_valid) begin
        if (first_v < 0) first_v = cyc;
        pid_q.push_back(rd_pid);
        data_q.push_back(rd_data);
      end
      if (rd_done) done_cyc = cyc;
    end
    rd_req = 1'b0;
    check("rd_done_seen", done_cyc >= 0, 1'b1);
  endtask

  task automatic do_write(input int n, input bit end_with_last, input logic [DW-1:0] seed);
    logic [DW-1:0] exp_mem [0:PN-1];
    int cnt, guard, done_n;
    bit ovf;
    for (int i = 0; i < PN; i++) exp_mem[i] = mem[i];
    cnt = 0; ovf = 1'b0; guard = 0; done_n = 0;
    check("wr_ovf_sticky", wr_ovf, last_ovf);
    wr_req = 1'b1;
    @(negedge clk);
    while (!wr_gnt && guard < 50) begin @(negedge clk); guard++; end
    check("wr_gnt_seen", wr_gnt, 1'b1);
    wr_req = 1'b0;
    check("wr_ovf_cleared", wr_ovf, 1'b0);
    check("wr_ready", wr_ready, 1'b1);
    for (int k = 0; k < n; k++) begin
      wr_valid = 1'b1;
      wr_data  = seed + DW'(k);
      wr_end   = end_with_last && (k == n - 1);
      if (cnt < PN - 1) begin exp_mem[cnt + 1] = wr_data; cnt++; end
      else ovf = 1'b1;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    if (!end_with_last) begin wr_end = 1'b1; @(negedge clk); end
    wr_end = 1'b0;
    exp_mem[0] = DW'(cnt);
    for (int i = 0; i < 6; i++) begin
      if (wr_done) begin done_n++; check("wr_ovf", wr_ovf, ovf); end
      @(negedge clk);
    end
    check("wr_done_pulses", done_n, 1);
    for (int i = 0; i < PN; i++) check($sformatf("mem_word%0d", i), mem[i], exp_mem[i]);
    last_ovf = ovf;
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    last_ovf = 1'b0;
  endtask

  localparam logic [DW-1:0] WA = 96'h0000_00a1_0000_00a2_0000_00a3;
  localparam logic [DW-1:0] WB = 96'h0000_00b1_0000_00b2_0000_00b3;
  localparam logic [DW-1:0] WC = 96'h0000_00c1_0000_00c2_0000_00c3;
  localparam logic [DW-1:0] D0 = 96'h1111_0000_2222_0000_3333_0000;

  int order[$];

  initial begin
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < PN; i++) poke(i, '0);
    check("reset_state", all_outs(), '0);
    #2 rst = 1'b1;

    // Three-particle stream
    poke(0, DW'(3)); poke(1, WA); poke(2, WB); poke(3, WC);
    do_read(40);
    check("rd3_addr_n", addr_q.size(), 4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++) check("rd3_addr", addr_q[i], i);
    check("rd3_pid_n", pid_q.size(), 3);
    if (pid_q.size() == 3) begin
      check("rd3_pid0", pid_q[0], 1); check("rd3_pid2", pid_q[2], 3);
      check("rd3_dA", data_q[0], WA); check("rd3_dB", data_q[1], WB); check("rd3_dC", data_q[2], WC);
    end
    check("rd3_first_lat", first_v - g_cyc, 6);
    check("rd3_done_lat", done_cyc - g_cyc, 8);

    // Empty cell
    poke(0, '0);
    do_read(40);
    check("rd0_done_lat", done_cyc - g_cyc, 3);
    check("rd0_no_valid", pid_q.size(), 0);
    check("rd0_addr_n", addr_q.size(), 1);

    // Five-word refill, then read back
    do_write(5, 1'b0, D0);
    do_read(40);
    check("rdw_n", pid_q.size(), 5);
    for (int i = 0; i < 5 && i < data_q.size(); i++) check("rdw_data", data_q[i], D0 + DW'(i));

    // Overflow: nine words into a seven-particle cell, then a clearing write
    do_write(9, 1'b1, D0 + 96'h100);
    check("ovf_sticky", wr_ovf, 1'b1);
    do_write(2, 1'b0, D0 + 96'h200);

    // Count beyond capacity is clamped; reset mid-stream abandons it
    poke(0, DW'(10));
    for (int i = 1; i < PN; i++) poke(i, WA + DW'(i));
    do_read(40);
    check("clamp_n", pid_q.size(), PN - 1);
    rd_req = 1'b1;
    for (int i = 0; i < 30 && !(rd_valid && rd_pid == 2); i++) @(negedge clk);
    check("mid_stream_reached", rd_valid && rd_pid == 2, 1'b1);
    #1 rst = 1'b0;
    #1 check("async_reset_outputs", all_outs(), '0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    last_ovf = 1'b0;
    do_read(40);
    check("restart_addr0", addr_q.size() > 0 ? addr_q[0] : 8'hff, 0);
    check("restart_addr_n", addr_q.size(), PN);
    check("restart_pid_n", pid_q.size(), PN - 1);

    // Round robin with both requesters continuously asking
    pulse_reset();
    poke(0, DW'(3));
    rd_req = 1'b1; wr_req = 1'b1;
    for (int i = 0; i < 120 && order.size() < 4; i++) begin
      @(negedge clk);
      wr_end = 1'b0;
      if (rd_gnt) order.push_back(0);
      if (wr_gnt) begin order.push_back(1); wr_end = 1'b1; end
    end
    rd_req = 1'b0; wr_req = 1'b0;
    @(negedge clk);
    wr_end = 1'b0;
    repeat (12) @(negedge clk);
    check("rr_grants", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++) check($sformatf("rr_grant%0d", i), order[i], i % 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
